// File: rtl/dqn_weight_pkg.sv
// Shared definitions for the DQN weight RAM, its writer and its read controller.
//   - layer codes driven on the RAM layer select
//   - beat-count helpers: words per layer = nodes * (fan-in + 1 bias)
//   - clog2 helper for sizing counters
//   - writer FSM state type
package dqn_weight_pkg;

  localparam logic [1:0] LAYER_NONE     = 2'b00;
  localparam logic [1:0] LAYER_HIDDEN_1 = 2'b01;
  localparam logic [1:0] LAYER_HIDDEN_2 = 2'b10;
  localparam logic [1:0] LAYER_OUTPUT   = 2'b11;

  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int beats_l1(input int n_in, input int n_h1);
    return n_h1 * (n_in + 1);
  endfunction

  function automatic int beats_l2(input int n_h1, input int n_h2);
    return n_h2 * (n_h1 + 1);
  endfunction

  function automatic int beats_l3(input int n_h2, input int n_out);
    return n_out * (n_h2 + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Writer sequencer states
  //   ST_IDLE   | waiting for i_start, upstream stalled
  //   ST_WR_L1  | accepting hidden-1 weights (layer 01)
  //   ST_WR_L2  | accepting hidden-2 weights (layer 10)
  //   ST_WR_L3  | accepting output weights   (layer 11)
  //   ST_FINISH | last strobe on the bus; o_done follows
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_L1  = 3'd1,
    ST_WR_L2  = 3'd2,
    ST_WR_L3  = 3'd3,
    ST_FINISH = 3'd4
  } wr_state_e;

endpackage

// File: rtl/weight_ram_writer.sv
// Write-side sequencer for the layer weight RAM.
// Takes a flat weight stream (valid/ready) and writes it to the RAM as
// hidden-1, hidden-2, then output layer, issuing exactly the number of beats
// the RAM's own write pointer expects for each layer.
// Ports:
//   clk, rst           clock, async active-high reset
//   i_start            pulse: begin a full three-layer load (ignored while busy)
//   i_valid/i_weight   upstream stream; o_ready is the accept side
//   o_ram_enable       write strobe, one cycle after each accepted beat
//   o_rw_select        always 0 (write); reads are owned by the read side
//   o_layer/o_weight   RAM layer code and data, held between strobes
//   o_busy             load in progress
//   o_done             one-cycle pulse after the final strobe
module weight_ram_writer
  import dqn_weight_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_valid,
  input  logic [DATA_WIDTH-1:0]  i_weight,
  output logic                   o_ready,
  output logic                   o_ram_enable,
  output logic                   o_rw_select,
  output logic [LAYER_WIDTH-1:0] o_layer,
  output logic [DATA_WIDTH-1:0]  o_weight,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int N1 = beats_l1(NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1);
  localparam int N2 = beats_l2(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2);
  localparam int N3 = beats_l3(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  localparam int CNT_RAW = clog2(max3(N1, N2, N3));
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  localparam logic [CNT_W-1:0] LAST_L1 = CNT_W'(N1 - 1);
  localparam logic [CNT_W-1:0] LAST_L2 = CNT_W'(N2 - 1);
  localparam logic [CNT_W-1:0] LAST_L3 = CNT_W'(N3 - 1);

  wr_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ram_en_q, ram_en_d;
  logic [LAYER_WIDTH-1:0] layer_q, layer_d;
  logic [DATA_WIDTH-1:0]  weight_q, weight_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   ready;
  logic [LAYER_WIDTH-1:0] cur_layer;
  logic [CNT_W-1:0]       cur_last;
  wr_state_e              after_layer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ram_en_q <= 1'b0;
      layer_q  <= '0;
      weight_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ram_en_q <= ram_en_d;
      layer_q  <= layer_d;
      weight_q <= weight_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_en_d    = 1'b0;
    layer_d     = layer_q;
    weight_d    = weight_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ready       = 1'b0;
    cur_layer   = LAYER_WIDTH'(LAYER_NONE);
    cur_last    = LAST_L1;
    after_layer = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        // While o_done is still high the previous load is being retired,
        // so a start pulse landing on it is dropped.
        if (i_start && !done_q) begin
          state_d = ST_WR_L1;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_WR_L1: begin
        ready       = 1'b1;
        cur_layer   = LAYER_WIDTH'(LAYER_HIDDEN_1);
        cur_last    = LAST_L1;
        after_layer = ST_WR_L2;
      end
      ST_WR_L2: begin
        ready       = 1'b1;
        cur_layer   = LAYER_WIDTH'(LAYER_HIDDEN_2);
        cur_last    = LAST_L2;
        after_layer = ST_WR_L3;
      end
      ST_WR_L3: begin
        ready       = 1'b1;
        cur_layer   = LAYER_WIDTH'(LAYER_OUTPUT);
        cur_last    = LAST_L3;
        after_layer = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Shared accept path for the three write states. The counter stops at
    // the layer's last index and restarts at 0, tracking the RAM pointer.
    if (ready && i_valid) begin
      ram_en_d = 1'b1;
      layer_d  = cur_layer;
      weight_d = i_weight;
      if (cnt_q == cur_last) begin
        cnt_d   = '0;
        state_d = after_layer;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_ready      = ready;
  assign o_ram_enable = ram_en_q;
  assign o_rw_select  = 1'b0;
  assign o_layer      = layer_q;
  assign o_weight     = weight_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_weight_ram_writer.sv
module tb_weight_ram_writer;

  localparam int IN_N  = 2;
  localparam int H1    = 32;
  localparam int H2    = 32;
  localparam int OUT_N = 3;
  localparam int N1    = H1 * (IN_N + 1);
  localparam int N2    = H2 * (H1 + 1);
  localparam int N3    = OUT_N * (H2 + 1);
  localparam int TOTAL = N1 + N2 + N3;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_valid;
  logic [31:0] i_weight;
  logic        o_ready;
  logic        o_ram_enable;
  logic        o_rw_select;
  logic [1:0]  o_layer;
  logic [31:0] o_weight;
  logic        o_busy;
  logic        o_done;

  weight_ram_writer dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .i_weight     (i_weight),
    .o_ready      (o_ready),
    .o_ram_enable (o_ram_enable),
    .o_rw_select  (o_rw_select),
    .o_layer      (o_layer),
    .o_weight     (o_weight),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  layer;
    logic [31:0] w;
  } beat_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } dchk_t;

  // written only by the stimulus process
  beat_t sq[$];
  dchk_t dq[$];

  // written only by the monitor process
  int          checks = 0;
  int          errors = 0;
  int          sq_rd = 0;
  int          dq_rd = 0;
  int          strobes = 0;
  int          done_cnt = 0;
  int          cur_run = 0;
  int          last_run = 0;
  logic        last_en = 1'b0;
  logic [31:0] ram1 [N1];
  logic [31:0] ram2 [N2];
  logic [31:0] ram3 [N3];
  int          p1 = 0, p2 = 0, p3 = 0;

  function automatic logic [1:0] layer_of(input int k);
    if (k < N1) return 2'b01;
    if (k < N1 + N2) return 2'b10;
    return 2'b11;
  endfunction

  function automatic void expect_eq(input string n, input logic [63:0] a, input logic [63:0] e);
    dchk_t d;
    d.name = n;
    d.act  = a;
    d.exp  = e;
    dq.push_back(d);
  endfunction

  // Monitor / scoreboard
  initial begin
    beat_t b;
    dchk_t d;
    forever begin
      @(negedge clk);
      while (dq_rd < dq.size()) begin
        d = dq[dq_rd];
        dq_rd = dq_rd + 1;
        checks = checks + 1;
        if (d.act !== d.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got %0h expected %0h", d.name, d.act, d.exp);
        end
      end
      if (rst) begin
        sq_rd   = sq.size();
        last_en = 1'b0;
        cur_run = 0;
      end else begin
        checks = checks + 1;
        if (o_rw_select !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL rw_select: got %b expected 0", o_rw_select);
        end
        if (o_ram_enable) begin
          checks = checks + 1;
          if (sq_rd >= sq.size()) begin
            errors = errors + 1;
            $display("FAIL unexpected_strobe: got layer %b weight %0h expected no strobe", o_layer, o_weight);
          end else begin
            b = sq[sq_rd];
            sq_rd = sq_rd + 1;
            if (o_layer !== b.layer || o_weight !== b.w) begin
              errors = errors + 1;
              $display("FAIL beat: got layer %b weight %0h expected layer %b weight %0h",
                       o_layer, o_weight, b.layer, b.w);
            end
          end
          case (o_layer)
            2'b01: begin ram1[p1] = o_weight; p1 = (p1 + 1) % N1; end
            2'b10: begin ram2[p2] = o_weight; p2 = (p2 + 1) % N2; end
            2'b11: begin ram3[p3] = o_weight; p3 = (p3 + 1) % N3; end
            default: ;
          endcase
          strobes = strobes + 1;
          cur_run = cur_run + 1;
        end else begin
          if (cur_run > 0) last_run = cur_run;
          cur_run = 0;
        end
        if (o_done) begin
          done_cnt = done_cnt + 1;
          checks = checks + 1;
          if (!(last_en && sq_rd == sq.size() && !o_busy && !o_ram_enable)) begin
            errors = errors + 1;
            $display("FAIL done_pulse: got prev_strobe %b pending %0d busy %b expected 1 0 0",
                     last_en, sq.size() - sq_rd, o_busy);
          end
        end
        last_en = o_ram_enable;
      end
    end
  end

  // mode 0: valid held 1, mode 1: valid toggles 1-0, mode 2: random valid
  task automatic run_load(input int mode, input int mult, input int restart_at, input int abort_at);
    int   k;
    int   cyc;
    int   s0;
    int   d0;
    bit   tog;
    bit   restarted;
    bit   got_done;
    beat_t b;
    k = 0;
    cyc = 0;
    tog = 1'b1;
    restarted = 1'b0;
    s0 = strobes;
    d0 = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    expect_eq("ready_after_start", {63'd0, o_ready}, 64'd1);
    expect_eq("busy_after_start", {63'd0, o_busy}, 64'd1);
    while (k < TOTAL && cyc < 12000) begin
      case (mode)
        0: i_valid = 1'b1;
        1: begin i_valid = tog; tog = ~tog; end
        default: i_valid = ($urandom_range(0, 3) != 0);
      endcase
      i_weight = 32'(k * mult);
      i_start  = (restart_at >= 0 && k == restart_at && !restarted);
      if (i_start) restarted = 1'b1;
      @(negedge clk);
      if (i_valid && o_ready) begin
        b.layer = layer_of(k);
        b.w     = i_weight;
        sq.push_back(b);
        k = k + 1;
      end
      @(posedge clk); #1;
      cyc = cyc + 1;
      if (abort_at >= 0 && k == abort_at) begin
        i_valid = 1'b0;
        i_start = 1'b0;
        rst = 1'b1;
        #1;
        expect_eq("reset_mid_load", {56'd0, o_ready, o_ram_enable, o_busy, o_done, o_rw_select, o_layer, 1'b0},
                  64'd0);
        expect_eq("reset_mid_weight", {32'd0, o_weight}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    if (k < TOTAL) expect_eq("load_timeout", 64'(k), 64'(TOTAL));
    expect_eq("finish_ready", {63'd0, o_ready}, 64'd0);
    expect_eq("finish_busy", {63'd0, o_busy}, 64'd1);
    got_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_done) begin got_done = 1'b1; break; end
    end
    expect_eq("done_seen", {63'd0, got_done}, 64'd1);
    // start landing on the o_done cycle must be ignored
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    expect_eq("start_on_done_busy", {63'd0, o_busy}, 64'd0);
    expect_eq("start_on_done_ready", {63'd0, o_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    expect_eq("done_count", 64'(done_cnt - d0), 64'd1);
    expect_eq("strobe_count", 64'(strobes - s0), 64'(TOTAL));
    if (mode == 0) expect_eq("strobe_run", 64'(last_run), 64'(TOTAL));
  endtask

  initial begin
    int bad1;
    int bad3;
    rst      = 1'b1;
    i_start  = 1'b0;
    i_valid  = 1'b0;
    i_weight = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("reset_outputs", {56'd0, o_ready, o_ram_enable, o_busy, o_done, o_rw_select, o_layer, 1'b0}, 64'd0);
    expect_eq("reset_weight", {32'd0, o_weight}, 64'd0);
    rst = 1'b0;

    // junk while idle
    i_valid  = 1'b1;
    i_weight = 32'hDEADBEEF;
    repeat (5) begin
      @(posedge clk); #1;
      expect_eq("idle_ready", {63'd0, o_ready}, 64'd0);
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    expect_eq("idle_weight", {32'd0, o_weight}, 64'd0);
    expect_eq("idle_strobes", 64'(strobes), 64'd0);

    run_load(0, 1, -1, -1);
    run_load(1, 1, N1 + 500, -1);
    run_load(2, 3, -1, -1);

    bad1 = 0;
    bad3 = 0;
    for (int i = 0; i < N1; i++) if (ram1[i] !== 32'(3 * i)) bad1++;
    for (int i = 0; i < N3; i++) if (ram3[i] !== 32'(3 * (N1 + N2 + i))) bad3++;
    expect_eq("ram_layer01_bad_words", 64'(bad1), 64'd0);
    expect_eq("ram_layer11_bad_words", 64'(bad3), 64'd0);

    run_load(0, 5, -1, N1 + 500);
    run_load(2, 7, -1, -1);

    repeat (4) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/weight_ram_writer.md
Name: weight_ram_writer

Overview:
- Write-side sequencer for the layer weight RAM. It accepts a flat stream of weights from an upstream source, either the external loader or the weight-update path, using a valid/ready handshake.
- It drives the RAM write port (enable, rw_select=0, layer, weight) for hidden 1, hidden 2 and output layers in that order, issuing exactly the beat count the RAM's internal write pointer expects per layer.
- Signals completion so the forward-pass controller can start reading.

Parameters:
- DATA_WIDTH, 32, weight word width
- LAYER_WIDTH, 2, layer code width
- NUMBER_OF_INPUT_NODE, 2, input nodes
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, hidden layer 1 nodes
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, hidden layer 2 nodes
- NUMBER_OF_OUTPUT_NODE, 3, output nodes

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse; begins a full three-layer load
- i_valid  in  1  upstream weight valid
- i_weight  in  DATA_WIDTH  upstream weight word
- o_ready  out  1  writer accepts i_weight this cycle
- o_ram_enable  out  1  RAM enable (write strobe)
- o_rw_select  out  1  RAM read/write select; constant 0 (write)
- o_layer  out  LAYER_WIDTH  RAM layer code
- o_weight  out  DATA_WIDTH  RAM write data
- o_busy  out  1  load in progress
- o_done  out  1  one-cycle pulse after the final write strobe

Behaviour:
- Beat counts per layer:
  - N1 = H1*(IN+1) = 96
  - N2 = H2*(H1+1) = 1056
  - N3 = OUT*(H2+1) = 99
  - Total 1251 at defaults.
- Beat counter width is clog2(max(N1,N2,N3)), 11 bits at defaults. The counter compares against N-1 and never wraps past it.
- Reset values (asynchronous): state IDLE, counter 0, o_ready 0, o_ram_enable 0, o_rw_select 0, o_layer 2'b00, o_weight 0, o_busy 0, o_done 0.
- FSM states: IDLE, WR_L1 (layer 2'b01), WR_L2 (2'b10), WR_L3 (2'b11), FINISH.
- IDLE:
  - o_ready=0; i_valid is ignored.
  - i_start=1 -> WR_L1, counter=0, o_busy=1 from the next cycle.
- WR_Lx:
  - o_ready=1 (combinational from state).
  - Accepted beat = i_valid & o_ready.
  - On an accepted beat, the next cycle has o_ram_enable=1, o_layer=x and o_weight=i_weight (registered, 1-cycle latency), and the counter increments.
  - Cycles without an accepted beat give o_ram_enable=0 next cycle; o_layer and o_weight hold their last value.
- Layer transition: an accepted beat with counter==Nx-1 resets the counter to 0 and moves to the next state (WR_L1->WR_L2->WR_L3->FINISH).
  - A beat accepted in the first cycle of the new state is legal and is written with the new layer code. Back-to-back beats across layers need no gap.
  - This aligns with the RAM's internal pointer, which wraps to 0 after its own last beat.
- FINISH:
  - o_ready=0; the final write strobe is on the bus this cycle.
  - Next cycle: o_done=1 for exactly one cycle, o_busy=0, return to IDLE.
- i_start while o_busy=1 is ignored; no restart and no counter change.
- i_start in the same cycle as o_done is ignored; a new i_start is accepted from IDLE the following cycle.
- o_rw_select is held at 0 at all times. The writer never issues reads; the read side owns rw_select=1 and shares the RAM enable through an external mux.
- Reset mid-load:
  - The writer returns to IDLE immediately and o_ram_enable drops asynchronously.
  - The RAM's write pointer has no reset. The system constraint is that a writer reset is only applied together with a system-wide power-on reset; a mid-load reset leaves RAM contents undefined.
- No layer may be partially written. Upstream must supply all 1251 words per load; stalls of any length are tolerated.

Decomposition:
- Shared package (dqn_weight_pkg), used by the RAM, this writer and the read controller:
  - layer code constants LAYER_HIDDEN_1=2'b01, LAYER_HIDDEN_2=2'b10, LAYER_OUTPUT=2'b11;
  - beat-count functions N1/N2/N3 from the node parameters;
  - clog2 function;
  - FSM state typedef.
- No sub-module is needed. The counter and FSM fit in one block (about 150 lines).

Test Plan:
- Full load, i_valid held 1, words = 0..1250 after i_start:
  - o_ram_enable high for exactly 1251 consecutive cycles starting 1 cycle after the first accept.
  - o_layer=01 for words 0..95, 10 for words 96..1151, 11 for words 1152..1250.
  - o_done pulses once, the cycle after the last strobe.
- Stalled stream, i_valid toggling 1-0-1-0:
  - o_ram_enable high only on the cycle after each accept; o_weight values in order; total strobes still 1251.
- i_start pulsed again in mid-L2 -> ignored: counter continues, no extra o_done, layer sequence unchanged.
- i_valid=1 with i_weight=0xDEADBEEF while IDLE -> o_ready=0, no o_ram_enable, o_weight unchanged.
- Assert rst at word 500 of L2 -> all outputs return to their reset values immediately; a new i_start after release restarts at layer 01, counter 0.
- Integration with the weight RAM:
  - full load of the pattern w[k] = k*3, then a read of layer 11 -> RAM returns 99 words equal to 3*(1152..1250) in order;
  - a read of layer 01 returns 3*(0..95).
